// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback/debug request and register-file write port bundle
interface rf_write_arbiter_if #(
  parameter int INST_SZ     = 32,
  parameter int REG_ADDR_SZ = 5
);
  logic                   i_reg_write_W;
  logic [REG_ADDR_SZ-1:0] i_write_reg_W;
  logic [INST_SZ-1:0]     i_write_data_W;
  logic                   i_dbg_valid;
  logic [REG_ADDR_SZ-1:0] i_dbg_addr;
  logic [INST_SZ-1:0]     i_dbg_data;
  logic                   o_dbg_ready;
  logic                   o_dbg_done;
  logic                   o_stall_req;
  logic                   o_rf_we;
  logic [REG_ADDR_SZ-1:0] o_rf_addr;
  logic [INST_SZ-1:0]     o_rf_data;

  modport slave (
    input  i_reg_write_W, i_write_reg_W, i_write_data_W,
    input  i_dbg_valid, i_dbg_addr, i_dbg_data,
    output o_dbg_ready, o_dbg_done, o_stall_req,
    output o_rf_we, o_rf_addr, o_rf_data
  );

  modport master (
    output i_reg_write_W, i_write_reg_W, i_write_data_W,
    output i_dbg_valid, i_dbg_addr, i_dbg_data,
    input  o_dbg_ready, o_dbg_done, o_stall_req,
    input  o_rf_we, o_rf_addr, o_rf_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between writeback and debug
module rf_write_arbiter #(
  parameter int INST_SZ      = 32,
  parameter int REG_ADDR_SZ  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  rf_write_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, PENDING, STALL} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       starve_cnt;
  logic [REG_ADDR_SZ-1:0] hold_addr;
  logic [INST_SZ-1:0]     hold_data;
  logic                   dbg_done_q;

  logic                   dbg_ready;
  logic                   handshake;
  logic                   issue;
  logic                   sel_we;
  logic [REG_ADDR_SZ-1:0] sel_addr;
  logic [INST_SZ-1:0]     sel_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = PENDING;
      PENDING: begin
        if (!bus.i_reg_write_W)       state_nxt = IDLE;
        else if (starve_cnt == CNT_TRIP) state_nxt = STALL;
      end
      STALL:   if (!bus.i_reg_write_W) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writeback always wins the port; the held debug entry only fills idle writeback cycles.
  always_comb begin
    dbg_ready = (state == IDLE) && !i_reset;
    handshake = bus.i_dbg_valid && dbg_ready;
    issue     = (state != IDLE) && !bus.i_reg_write_W;
    sel_we    = 1'b0;
    sel_addr  = bus.i_write_reg_W;
    sel_data  = bus.i_write_data_W;
    if (bus.i_reg_write_W) begin
      sel_we = 1'b1;
    end else if (state != IDLE) begin
      sel_we   = 1'b1;
      sel_addr = hold_addr;
      sel_data = hold_data;
    end
  end

  assign bus.o_dbg_ready = dbg_ready;
  assign bus.o_dbg_done  = dbg_done_q;
  assign bus.o_stall_req = (state == STALL);
  assign bus.o_rf_we     = sel_we && (sel_addr != '0) && !i_reset;
  assign bus.o_rf_addr   = sel_addr;
  assign bus.o_rf_data   = sel_data;

  // Counts writeback-busy cycles while pending; saturates so a long stall never wraps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (handshake) begin
      starve_cnt <= '0;
    end else if ((state == PENDING) && bus.i_reg_write_W && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (handshake) begin
      hold_addr <= bus.i_dbg_addr;
      hold_data <= bus.i_dbg_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) dbg_done_q <= 1'b0;
    else         dbg_done_q <= issue;
  end
endmodule
